// File: rtl/pipe_reg_chain_if.sv
// rtl/pipe_reg_chain_if.sv - control, input and output bundle of the pipeline register chain
interface pipe_reg_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
);
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [DEPTH-1:0] squash;
    logic [DEPTH-1:0] stage_vld;
    logic             q_valid;
    logic [WIDTH-1:0] q_data;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output en, in_valid, in_data, squash,
        input  stage_vld, q_valid, q_data, stall_cnt
    );

    modport slave (
        input  en, in_valid, in_data, squash,
        output stage_vld, q_valid, q_data, stall_cnt
    );
endinterface

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage valid/data pipeline register with stall and per-stage squash; optional stall counter under PIPE_STALL_CNT_EN
module pipe_reg_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_reg_chain_if.slave   bus
);
    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] live;

    // An entry survives this edge only if it is valid and not being killed.
    assign live = vld & ~bus.squash;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else if (bus.en) begin
            vld[0]  <= bus.in_valid;
            data[0] <= bus.in_valid ? bus.in_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i]  <= live[i-1];
                data[i] <= live[i-1] ? data[i-1] : '0;
            end
        end else begin
            // Stalled: live entries hold, squashed ones collapse to bubbles in place.
            for (int i = 0; i < DEPTH; i++) begin
                if (!live[i]) begin
                    vld[i]  <= 1'b0;
                    data[i] <= '0;
                end
            end
        end
    end

    assign bus.stage_vld = vld;
    assign bus.q_valid   = vld[DEPTH-1];
    assign bus.q_data    = data[DEPTH-1];

`ifdef PIPE_STALL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!bus.en && vld[DEPTH-1] && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign bus.stall_cnt = cnt;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - directed self-checking bench for pipe_reg_chain
module tb_pipe_reg_chain;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
`ifdef PIPE_STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    pipe_reg_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic iv,
                         input logic [WIDTH-1:0] d, input logic [DEPTH-1:0] sq);
        reset        = r;
        bus.en       = e;
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.squash   = sq;
    endtask

    task automatic fill_11_22();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 2'b00); step();
        drive(1'b0, 1'b1, 1'b1, 32'h11, 2'b00); step();
        drive(1'b0, 1'b1, 1'b1, 32'h22, 2'b00); step();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD, 2'b00);
        step(); step();
        total++; if (bus.stage_vld !== 2'b00) begin bad++; $display("FAIL reset_stage_vld got=%b exp=00", bus.stage_vld); end
        total++; if (bus.q_valid !== 1'b0) begin bad++; $display("FAIL reset_q_valid got=%b exp=0", bus.q_valid); end
        total++; if (bus.q_data !== 32'h0) begin bad++; $display("FAIL reset_q_data got=%h exp=0", bus.q_data); end
        total++; if (bus.stall_cnt !== 4'h0) begin bad++; $display("FAIL reset_stall_cnt got=%h exp=0", bus.stall_cnt); end
    endtask

    task automatic test_flow();
        logic [WIDTH-1:0] exp_q [5];
        logic             exp_v [5];
        logic [WIDTH-1:0] in_d  [5];
        logic             in_v  [5];
        in_d = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0};
        in_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_q = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, in_v[i], in_d[i], 2'b00);
            step();
            total++; if (bus.q_valid !== exp_v[i]) begin bad++; $display("FAIL flow_q_valid edge=%0d got=%b exp=%b", i + 1, bus.q_valid, exp_v[i]); end
            total++; if (bus.q_data !== exp_q[i]) begin bad++; $display("FAIL flow_q_data edge=%0d got=%h exp=%h", i + 1, bus.q_data, exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        fill_11_22();
        drive(1'b0, 1'b0, 1'b1, 32'h99, 2'b00);
        step(); step(); step();
        total++; if (bus.q_data !== 32'h11) begin bad++; $display("FAIL stall_q_data got=%h exp=11", bus.q_data); end
        total++; if (bus.q_valid !== 1'b1) begin bad++; $display("FAIL stall_q_valid got=%b exp=1", bus.q_valid); end
        total++; if (bus.stage_vld !== 2'b11) begin bad++; $display("FAIL stall_stage_vld got=%b exp=11", bus.stage_vld); end
        total++; if (bus.stall_cnt !== (CNT_ON ? 4'd3 : 4'd0)) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", bus.stall_cnt, CNT_ON ? 3 : 0); end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        step();
        total++; if (bus.q_data !== 32'h22) begin bad++; $display("FAIL stall_release_q_data got=%h exp=22", bus.q_data); end
        total++; if (bus.stall_cnt !== (CNT_ON ? 4'd3 : 4'd0)) begin bad++; $display("FAIL stall_release_cnt got=%0d exp=%0d", bus.stall_cnt, CNT_ON ? 3 : 0); end
    endtask

    task automatic test_squash_advance();
        fill_11_22();
        drive(1'b0, 1'b1, 1'b1, 32'h33, 2'b01);
        step();
        total++; if (bus.q_valid !== 1'b0) begin bad++; $display("FAIL sq_adv_q_valid got=%b exp=0", bus.q_valid); end
        total++; if (bus.q_data !== 32'h0) begin bad++; $display("FAIL sq_adv_q_data got=%h exp=0", bus.q_data); end
        total++; if (bus.stage_vld !== 2'b01) begin bad++; $display("FAIL sq_adv_stage_vld got=%b exp=01", bus.stage_vld); end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        step();
        total++; if (bus.q_data !== 32'h33) begin bad++; $display("FAIL sq_adv_next_q_data got=%h exp=33", bus.q_data); end
    endtask

    task automatic test_squash_last_advance();
        fill_11_22();
        drive(1'b0, 1'b1, 1'b1, 32'h33, 2'b10);
        step();
        total++; if (bus.q_data !== 32'h22) begin bad++; $display("FAIL sq_last_q_data got=%h exp=22", bus.q_data); end
        total++; if (bus.stage_vld !== 2'b11) begin bad++; $display("FAIL sq_last_stage_vld got=%b exp=11", bus.stage_vld); end
    endtask

    task automatic test_squash_stall();
        fill_11_22();
        drive(1'b0, 1'b0, 1'b1, 32'h77, 2'b10);
        step();
        total++; if (bus.q_valid !== 1'b0) begin bad++; $display("FAIL sq_stall_q_valid got=%b exp=0", bus.q_valid); end
        total++; if (bus.q_data !== 32'h0) begin bad++; $display("FAIL sq_stall_q_data got=%h exp=0", bus.q_data); end
        total++; if (bus.stage_vld !== 2'b01) begin bad++; $display("FAIL sq_stall_stage_vld got=%b exp=01", bus.stage_vld); end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        step();
        total++; if (bus.q_data !== 32'h22) begin bad++; $display("FAIL sq_stall_next_q_data got=%h exp=22", bus.q_data); end
    endtask

    task automatic test_saturation();
        fill_11_22();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14 || i == 15 || i == 20) begin
                total++;
                if (bus.stall_cnt !== (CNT_ON ? ((i > 15) ? 4'd15 : 4'(i)) : 4'd0)) begin
                    bad++;
                    $display("FAIL sat_cnt cycle=%0d got=%0d exp=%0d", i, bus.stall_cnt, CNT_ON ? ((i > 15) ? 15 : i) : 0);
                end
            end
        end
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD, 2'b00);
        step();
        total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL sat_reset_cnt got=%0d exp=0", bus.stall_cnt); end
        total++; if (bus.stage_vld !== 2'b00) begin bad++; $display("FAIL sat_reset_stage_vld got=%b exp=00", bus.stage_vld); end
        total++; if (bus.q_data !== 32'h0) begin bad++; $display("FAIL sat_reset_q_data got=%h exp=0", bus.q_data); end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
        test_reset();
        test_flow();
        test_stall();
        test_squash_advance();
        test_squash_last_advance();
        test_squash_stall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
